// File: rtl/tdp_ram_be_pipe.sv
// True dual-port RAM with byte enables and a 1- or 2-stage read pipeline.
// Every accepted access (read or write) returns one word RD_LAT cycles later.
module tdp_ram_be_pipe #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en_A,
    input  logic              wr_en_A,
    input  logic [DATA_W/8-1:0] be_A,
    input  logic [ADDR_W-1:0] addr_bus_A,
    input  logic [DATA_W-1:0] data_in_A,
    output logic [DATA_W-1:0] data_out_A,
    output logic              rd_valid_A,
    input  logic              en_B,
    input  logic              wr_en_B,
    input  logic [DATA_W/8-1:0] be_B,
    input  logic [ADDR_W-1:0] addr_bus_B,
    input  logic [DATA_W-1:0] data_in_B,
    output logic [DATA_W-1:0] data_out_B,
    output logic              rd_valid_B,
    output logic              collision
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              acc_a, acc_b, wr_a, wr_b;
    logic [DATA_W-1:0] old_a, old_b, merged_a, merged_b;
    logic [DATA_W-1:0] rdata_a_d, rdata_b_d;
    logic              collision_d;

    assign acc_a = en_A & ~reset;
    assign acc_b = en_B & ~reset;
    assign wr_a  = acc_a & wr_en_A;
    assign wr_b  = acc_b & wr_en_B;
    assign old_a = mem_q[addr_bus_A];
    assign old_b = mem_q[addr_bus_B];

    always_comb begin
        merged_a = old_a;
        merged_b = old_b;
        for (int i = 0; i < NB; i++) begin
            if (be_A[i]) merged_a[i*8 +: 8] = data_in_A[i*8 +: 8];
            if (be_B[i]) merged_b[i*8 +: 8] = data_in_B[i*8 +: 8];
        end
        // Cross-port reads always see the pre-write array; only the own write can bypass.
        rdata_a_d   = (RDW_MODE == 1 && wr_a) ? merged_a : old_a;
        rdata_b_d   = (RDW_MODE == 1 && wr_b) ? merged_b : old_b;
        collision_d = acc_a && acc_b && (addr_bus_A == addr_bus_B) && (wr_en_A || wr_en_B);
    end

    // B lanes are written first so A wins on lanes both ports enable.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_b && be_B[i]) mem_q[addr_bus_B][i*8 +: 8] <= data_in_B[i*8 +: 8];
            if (wr_a && be_A[i]) mem_q[addr_bus_A][i*8 +: 8] <= data_in_A[i*8 +: 8];
        end
    end

    logic [DATA_W-1:0] s1_data_a_q, s1_data_b_q;
    logic              s1_vld_a_q, s1_vld_b_q;
    logic              collision_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_data_a_q <= '0;
            s1_data_b_q <= '0;
            s1_vld_a_q  <= 1'b0;
            s1_vld_b_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            s1_vld_a_q  <= acc_a;
            s1_vld_b_q  <= acc_b;
            collision_q <= collision_d;
            if (acc_a) s1_data_a_q <= rdata_a_d;
            if (acc_b) s1_data_b_q <= rdata_b_d;
        end
    end

    assign collision = collision_q;

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] s2_data_a_q, s2_data_b_q;
            logic              s2_vld_a_q, s2_vld_b_q;

            // Stage one already holds its last word, so a plain copy keeps data_out stable.
            always_ff @(posedge clock) begin
                if (reset) begin
                    s2_data_a_q <= '0;
                    s2_data_b_q <= '0;
                    s2_vld_a_q  <= 1'b0;
                    s2_vld_b_q  <= 1'b0;
                end else begin
                    s2_data_a_q <= s1_data_a_q;
                    s2_data_b_q <= s1_data_b_q;
                    s2_vld_a_q  <= s1_vld_a_q;
                    s2_vld_b_q  <= s1_vld_b_q;
                end
            end

            assign data_out_A = s2_data_a_q;
            assign data_out_B = s2_data_b_q;
            assign rd_valid_A = s2_vld_a_q;
            assign rd_valid_B = s2_vld_b_q;
        end else begin : g_lat1
            assign data_out_A = s1_data_a_q;
            assign data_out_B = s1_data_b_q;
            assign rd_valid_A = s1_vld_a_q;
            assign rd_valid_B = s1_vld_b_q;
        end
    endgenerate

endmodule

// File: doc/tdp_ram_be_pipe.md
TDP_RAM_BE_PIPE -- requirements
Module: tdp_ram_be_pipe

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning address width; depth = 2**ADDR_W words.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning word width; legal values are multiples of 8; NB = DATA_W/8 byte lanes.
REQ-003 The block SHALL have parameter RD_LAT, default 1, meaning read latency in cycles; legal values 1 or 2.
REQ-004 The block SHALL have parameter RDW_MODE, default 0, meaning same-port read-during-write result: 0 = old data, 1 = new data.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on rising clock.
REQ-007 Ports A and B SHALL be identical, suffix _A/_B: en (in, 1, access request), wr_en (in, 1, write when en), be (in, NB, byte write enables), addr_bus (in, ADDR_W, word address), data_in (in, DATA_W, write data).
REQ-008 Each port SHALL have outputs data_out (DATA_W, read data) and rd_valid (1, data_out qualifier).
REQ-009 The block SHALL have output collision, 1 bit: same-address conflict flag.

Function
REQ-010 Access on a port SHALL be accepted only in a cycle where en=1 and reset=0; en=0 cycles SHALL leave memory, data_out and pipeline unchanged except valid shifting.
REQ-011 An accepted write SHALL update only byte lanes i with be[i]=1; lanes with be[i]=0 SHALL keep their prior value; wr_en=1 with be=0 SHALL change no memory.
REQ-012 Every accepted access (read or write) SHALL return a word on data_out exactly RD_LAT cycles later, with rd_valid=1 for exactly that one cycle per access.
REQ-013 For a same-port write, returned data SHALL be the pre-write word when RDW_MODE=0, and the post-write word (merged by be) when RDW_MODE=1.
REQ-014 data_out SHALL hold its last value while rd_valid=0.
REQ-015 Back-to-back accesses SHALL be fully pipelined: one access per port per cycle, no stalls.
REQ-016 Cross-port read of an address written by the other port in the same cycle SHALL return the pre-write word, regardless of RDW_MODE.
REQ-017 Both ports writing the same address in one cycle: lanes enabled on A SHALL take data_in_A; lanes enabled only on B SHALL take data_in_B.
REQ-018 collision SHALL pulse 1 for one cycle, the cycle after both ports are accepted with equal addr_bus and at least one wr_en=1; otherwise 0.
REQ-019 With RD_LAT=2, the second stage SHALL be a pure register of stage one; valid SHALL track data through both stages.

Reset
REQ-020 While reset=1: data_out_A, data_out_B = 0; rd_valid_A, rd_valid_B = 0; collision = 0; all pipeline valid bits cleared.
REQ-021 Memory contents SHALL NOT be cleared by reset and SHALL be undefined after power-up.
REQ-022 Writes presented in a reset cycle SHALL be suppressed; reads in flight when reset asserts SHALL be discarded (no rd_valid after reset deasserts for them).
REQ-023 The first access accepted in the cycle after reset deasserts SHALL behave normally.

Verification
REQ-024 RD_LAT=1: write A addr 0x005 data 0xDEADBEEF be=0xF; next cycle read B addr 0x005 -> data_out_B=0xDEADBEEF, rd_valid_B=1 one cycle after read.
REQ-025 Word 0x11223344 at addr 0x010; write A be=0x2 data 0xAABBCCDD -> subsequent read returns 0x1122CC44.
REQ-026 RDW_MODE=0 vs 1: addr 0x020 holds 0x0; write A 0x12345678 be=0xF -> data_out_A=0x00000000 (mode 0) / 0x12345678 (mode 1) RD_LAT cycles later.
REQ-027 Same cycle A write 0xAAAAAAAA be=0x3, B write 0xBBBBBBBB be=0xF, addr 0x030 -> word 0xBBBBAAAA; collision=1 next cycle only.
REQ-028 RD_LAT=2: reads on A every cycle to addr 1,2,3 -> data for addr 1,2,3 on cycles +2,+3,+4 with rd_valid_A continuously 1.
REQ-029 Reset asserted one cycle after read issue with RD_LAT=2 -> no rd_valid pulse, data_out=0; write issued during reset leaves target word unchanged.
